contra_rom_arbiter: RTL and testbench
=====================================

# contra_rom_arbiter

Shares one synchronous single-port graphics ROM (sprite/tile image ROM plus palette index output) between several fetch requesters: the VGA pixel mapper, the sprite engine and the tile-update logic. Uses per-requester valid/ready request handshakes and a tagged, fixed-latency response. During active video, requester 0 (the display mapper) has strict priority, protected by a starvation guard for the others. During blanking, grants rotate round-robin. Sits between the requesters and the `*_rom` instance, in the `vga_clk` domain.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; index 0 is the display mapper
- ADDR_W, 15, ROM address width
- DATA_W, 4, ROM word width (palette index)
- ROM_LAT, 1, ROM read latency in clocks (address sampled → q valid)
- STARVE_MAX, 15, consecutive active-video denials tolerated by a pending non-0 requester

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- blank  in  1  1 = active video (display window), 0 = blanking
- req_valid  in  NUM_REQ  per-requester request
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot or zero; handshake = valid & ready
- rsp_valid  out  NUM_REQ  one-hot or zero; marks rsp_data as belonging to requester i
- rsp_data  out  DATA_W  response word (= rom_q)
- rom_address  out  ADDR_W  registered ROM address
- rom_q  in  DATA_W  ROM read data

## Operation
- At most one grant per cycle. req_ready is combinational from req_valid, blank, the rotation pointer and the starvation counter. A requester must hold valid and addr stable until ready.
- Active video (blank=1):
  - Grant 0 if req_valid[0], otherwise apply round-robin among the rest.
  - Exception: if starve_cnt == STARVE_MAX and any non-0 request is pending, grant the round-robin winner among 1..NUM_REQ-1 even if req_valid[0]=1.
- Blanking (blank=0): round-robin over all requesters. The search starts at last_grant+1 mod NUM_REQ.
- last_grant updates on every handshake.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments when some non-0 request is pending and ungranted in active video, saturating at STARVE_MAX.
  - Clears on any non-0 grant, and whenever blank=0.
- On handshake, rom_address ← req_addr[winner] at the next edge. With no handshake, rom_address holds its value.
- Tag pipeline depth 1+ROM_LAT carries {valid, id}. rsp_valid[id] asserts when the tag emerges. rsp_data = rom_q, passed combinationally.
- Back-to-back grants are allowed every cycle (full throughput). Responses return in grant order.

## Timing
- Reset values: rom_address=0, rsp_valid=0, tag pipe cleared, starve_cnt=0, last_grant=NUM_REQ-1 (first round-robin pick is requester 0).
- req_ready is 0 during reset.
- Handshake in cycle t → rom_address valid in t+1 → rsp_valid/rsp_data in cycle t+1+ROM_LAT (t+2 at default).
- Reset asserted mid-flight: every in-flight tag is dropped. No rsp_valid is asserted for requests issued before reset.
- blank toggling: the policy follows the blank value sampled in the same cycle as the grant. In-flight responses are unaffected.
- Every requester deasserts valid: no grant, pointer and address hold, starve_cnt holds in active video.
- Single requester valid: granted every cycle regardless of mode.

## Structure
- Shared package contra_gfx_pkg holds:
  - ADDR_W/DATA_W defaults
  - req_id_t (logic [$clog2(NUM_REQ)-1:0])
  - the rsp_tag_t struct {logic v; req_id_t id;}
- One sub-module, contra_rr_picker: combinational round-robin picker.
  - Inputs: request mask, start index.
  - Outputs: one-hot grant and found flag.
  - Instantiated twice: once on the full mask, once on the mask with bit 0 cleared.

## Test plan
- Reset then idle: rsp_valid=0, rom_address=0. A single req_valid[2] with addr 0x1234 → ready same cycle, rom_address=0x1234 next cycle, rsp_valid=3'b100 two cycles after handshake, with rsp_data equal to the ROM model word at 0x1234.
- Blank=0, all three requesters valid continuously → grant sequence 0,1,2,0,1,2… with one response per cycle in matching order.
- Blank=1, req 0 and req 1 valid continuously → req 0 granted 15 cycles, then req 1 on the 16th, then the counter clears and the pattern repeats.
- Blank falls while req 1 is starving (starve_cnt=9) → starve_cnt=0 and round-robin resumes from last_grant+1.
- Assert reset with two responses in flight → neither rsp_valid appears. First post-reset request returns normally with correct latency.
- Randomized valid/addr with a ROM scoreboard: every handshake yields exactly one rsp_valid to the same id, with correct data, at t+1+ROM_LAT.

Source files
------------

// File: rtl/contra_gfx_pkg.sv
// Shared graphics-fetch types: ROM geometry defaults, requester id and response tag.
package contra_gfx_pkg;
  localparam int NUM_REQ_DEF = 3;
  localparam int ADDR_W_DEF  = 15;
  localparam int DATA_W_DEF  = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
  } rsp_tag_t;
endpackage

// File: rtl/contra_rom_arbiter_if.sv
// Requester/ROM bus seen by the graphics ROM arbiter.
interface contra_rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;

  modport master (output req_valid, req_addr, rom_q,
                  input  req_ready, rsp_valid, rsp_data, rom_address);
  modport slave  (input  req_valid, req_addr, rom_q,
                  output req_ready, rsp_valid, rsp_data, rom_address);
endinterface

// File: rtl/contra_rr_picker.sv
// Combinational round-robin picker: first set mask bit at or after i_start, wrapping.
module contra_rr_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_gnt,
  output logic          o_found
);
  always_comb begin
    o_gnt   = '0;
    o_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_found && i_mask[(int'(i_start) + k) % N]) begin
        o_gnt[(int'(i_start) + k) % N] = 1'b1;
        o_found                        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/contra_rom_arbiter.sv
// Shares one single-port graphics ROM among fetch requesters: display-priority with a
// starvation guard in active video, plain round-robin in blanking; tagged fixed-latency replies.
module contra_rom_arbiter
  import contra_gfx_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               blank,
  contra_rom_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  req_id_t             r_last;
  logic [SW-1:0]       r_starve;
  logic [ADDR_W-1:0]   r_addr;
  rsp_tag_t            r_tag [0:ROM_LAT];

  req_id_t             w_start;
  req_id_t             w_id;
  logic [NUM_REQ-1:0]  w_mask_rest;
  logic [NUM_REQ-1:0]  w_gnt_all;
  logic [NUM_REQ-1:0]  w_gnt_rest;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_found_all;
  logic                w_found_rest;
  logic                w_hs;

  assign w_start     = (r_last == req_id_t'(NUM_REQ - 1)) ? '0 : r_last + 1'b1;
  assign w_mask_rest = {bus.req_valid[NUM_REQ-1:1], 1'b0};

  contra_rr_picker #(.N(NUM_REQ), .IW($bits(req_id_t))) u_pick_all (
    .i_mask  (bus.req_valid),
    .i_start (w_start),
    .o_gnt   (w_gnt_all),
    .o_found (w_found_all)
  );

  contra_rr_picker #(.N(NUM_REQ), .IW($bits(req_id_t))) u_pick_rest (
    .i_mask  (w_mask_rest),
    .i_start (w_start),
    .o_gnt   (w_gnt_rest),
    .o_found (w_found_rest)
  );

  // Starvation override beats the display mapper once the guard saturates.
  always_comb begin
    w_gnt = '0;
    if (reset) begin
      w_gnt = '0;
    end else if (!blank) begin
      if (w_found_all) w_gnt = w_gnt_all;
    end else if (w_found_rest && r_starve == SW'(STARVE_MAX)) begin
      w_gnt = w_gnt_rest;
    end else if (bus.req_valid[0]) begin
      w_gnt    = '0;
      w_gnt[0] = 1'b1;
    end else begin
      w_gnt = w_gnt_rest;
    end
  end

  always_comb begin
    w_id = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_gnt[i]) w_id = req_id_t'(i);
  end

  assign w_hs          = |w_gnt;
  assign bus.req_ready = w_gnt;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_last   <= req_id_t'(NUM_REQ - 1);
      r_starve <= '0;
      r_addr   <= '0;
      for (int k = 0; k <= ROM_LAT; k++) r_tag[k] <= '0;
    end else begin
      if (w_hs) begin
        r_last <= w_id;
        r_addr <= bus.req_addr[int'(w_id)*ADDR_W +: ADDR_W];
      end
      if (!blank || (|w_gnt[NUM_REQ-1:1]))
        r_starve <= '0;
      else if (w_found_rest && r_starve != SW'(STARVE_MAX))
        r_starve <= r_starve + 1'b1;
      r_tag[0] <= '{v: w_hs, id: w_id};
      for (int k = 1; k <= ROM_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign bus.rom_address = r_addr;
  assign bus.rsp_data    = bus.rom_q;

  // Masking with reset hides a tag that is emerging in the very cycle reset arrives.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign bus.rsp_valid[i] = ~reset & r_tag[ROM_LAT].v & (r_tag[ROM_LAT].id == req_id_t'(i));
  end
endmodule

// File: tb/tb_contra_rom_arbiter.sv
// Directed bench for contra_rom_arbiter with a behavioural 1-cycle ROM.
module tb_contra_rom_arbiter;
  logic vga_clk;
  logic reset;
  logic blank;
  int   errs;
  int   checks;

  contra_rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(15), .DATA_W(4)) bus ();

  contra_rom_arbiter dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .blank   (blank),
    .bus     (bus)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [3:0] romf(input logic [14:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]};
  endfunction

  always @(posedge vga_clk) bus.rom_q <= romf(bus.rom_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic setreq(input logic [2:0] v, input logic [14:0] a0, a1, a2);
    bus.req_valid = v;
    bus.req_addr  = {a2, a1, a0};
  endtask

  logic [2:0]  g, h0, h1;
  logic [14:0] ha0, ha1;
  logic [14:0] ra [3];
  logic [2:0]  rv;

  initial begin
    errs = 0; checks = 0;
    reset = 1'b1; blank = 1'b0;
    setreq(3'b111, 15'h1, 15'h2, 15'h3);
    @(negedge vga_clk);
    chk("ready_in_reset", 32'(bus.req_ready), 32'h0);
    nxt(); nxt();
    reset = 1'b0;
    setreq(3'b000, 15'h0, 15'h0, 15'h0);
    @(negedge vga_clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_address), 32'h0);
    nxt();

    // single requester 2
    blank = 1'b1;
    setreq(3'b100, 15'h0, 15'h0, 15'h1234);
    @(negedge vga_clk);
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    nxt();
    setreq(3'b000, 15'h0, 15'h0, 15'h0);
    @(negedge vga_clk);
    chk("single_addr", 32'(bus.rom_address), 32'h1234);
    chk("single_no_rsp_yet", 32'(bus.rsp_valid), 32'h0);
    nxt();
    @(negedge vga_clk);
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("single_rsp_data", 32'(bus.rsp_data), 32'h4);
    nxt();

    // blanking round-robin, all valid; data words 1,2,3
    blank = 1'b0;
    for (int k = 0; k < 8; k++) begin
      setreq((k < 6) ? 3'b111 : 3'b000, 15'h1, 15'h2, 15'h3);
      @(negedge vga_clk);
      chk("rr_ready", 32'(bus.req_ready), (k < 6) ? 32'(1 << (k % 3)) : 32'h0);
      if (k >= 2) begin
        chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'(1 << ((k - 2) % 3)));
        chk("rr_rsp_data", 32'(bus.rsp_data), 32'((k - 2) % 3 + 1));
      end else begin
        chk("rr_rsp_idle", 32'(bus.rsp_valid), 32'h0);
      end
      nxt();
    end

    // active video, req 0 and 1: fifteen to 0, then one to 1
    blank = 1'b1;
    setreq(3'b011, 15'h1, 15'h2, 15'h3);
    for (int k = 0; k < 32; k++) begin
      @(negedge vga_clk);
      chk("starve_ready", 32'(bus.req_ready), ((k % 16) == 15) ? 32'h2 : 32'h1);
      nxt();
    end

    // build starve_cnt to 9, then blank falls: round-robin starts at last_grant+1 = 1
    for (int k = 0; k < 9; k++) begin
      @(negedge vga_clk);
      chk("pre_blank_ready", 32'(bus.req_ready), 32'h1);
      nxt();
    end
    blank = 1'b0;
    @(negedge vga_clk);
    chk("blank_fall_rr", 32'(bus.req_ready), 32'h2);
    nxt();
    blank = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge vga_clk);
      chk("pre_blank2_ready", 32'(bus.req_ready), 32'h1);
      nxt();
    end
    // blanking with only req 0: guard must clear from blank alone
    blank = 1'b0;
    setreq(3'b001, 15'h1, 15'h2, 15'h3);
    @(negedge vga_clk);
    chk("blank_only0", 32'(bus.req_ready), 32'h1);
    nxt();
    blank = 1'b1;
    setreq(3'b011, 15'h1, 15'h2, 15'h3);
    for (int k = 0; k < 16; k++) begin
      @(negedge vga_clk);
      chk("starve_cleared", 32'(bus.req_ready), (k == 15) ? 32'h2 : 32'h1);
      nxt();
    end

    // reset with two responses in flight
    blank = 1'b0;
    setreq(3'b001, 15'h5, 15'h6, 15'h7);
    @(negedge vga_clk);
    chk("inflight_a", 32'(bus.req_ready), 32'h1);
    nxt();
    setreq(3'b010, 15'h5, 15'h6, 15'h7);
    @(negedge vga_clk);
    chk("inflight_b", 32'(bus.req_ready), 32'h2);
    nxt();
    reset = 1'b1;
    setreq(3'b000, 15'h0, 15'h0, 15'h0);
    @(negedge vga_clk);
    chk("rst_drop_a", 32'(bus.rsp_valid), 32'h0);
    nxt();
    @(negedge vga_clk);
    chk("rst_drop_b", 32'(bus.rsp_valid), 32'h0);
    chk("rst_addr_clr", 32'(bus.rom_address), 32'h0);
    nxt();
    reset = 1'b0;
    @(negedge vga_clk);
    chk("post_rst_idle", 32'(bus.rsp_valid), 32'h0);
    nxt();
    blank = 1'b1;
    setreq(3'b100, 15'h0, 15'h0, 15'h7);
    @(negedge vga_clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'h4);
    nxt();
    setreq(3'b000, 15'h0, 15'h0, 15'h0);
    @(negedge vga_clk);
    chk("post_rst_addr", 32'(bus.rom_address), 32'h7);
    nxt();
    @(negedge vga_clk);
    chk("post_rst_rsp", 32'(bus.rsp_valid), 32'h4);
    chk("post_rst_data", 32'(bus.rsp_data), 32'h7);
    nxt();

    // randomized traffic with response scoreboard
    h0 = '0; h1 = '0; ha0 = '0; ha1 = '0;
    for (int i = 0; i < 3; i++) ra[i] = 15'($urandom);
    rv = 3'($urandom);
    for (int n = 0; n < 300; n++) begin
      if (n % 37 == 0) blank = 1'($urandom_range(0, 1));
      setreq(rv, ra[0], ra[1], ra[2]);
      @(negedge vga_clk);
      g = bus.req_ready;
      chk("rnd_ready_legal", 32'((g & ~rv) | (g & (g - 3'd1))), 32'h0);
      chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(h1));
      if (h1 != 3'b000) chk("rnd_rsp_data", 32'(bus.rsp_data), 32'(romf(ha1)));
      h1 = h0; ha1 = ha0;
      h0 = g;
      for (int i = 0; i < 3; i++) if (g[i]) ha0 = ra[i];
      nxt();
      for (int i = 0; i < 3; i++) begin
        if (!rv[i] || g[i]) begin
          rv[i] = 1'($urandom_range(0, 1));
          ra[i] = 15'($urandom);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
